// File: rtl/addsub_arbiter_pkg.sv
// Shared constants for the add/sub arbiter: sequencer states and requester ids.
package addsub_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_e;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // The shared adder is a fixed 16-bit block.
  localparam int ADDER_W = 16;

endpackage

// File: rtl/addsub_16bit.sv
// 16-bit two's-complement adder/subtractor.
// Ports:
//   A, B      operands
//   sub       0 = A+B, 1 = A-B
//   Sum       low 16 bits of the result
//   overflow  signed overflow of the selected operation
module addsub_16bit (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        sub,
  output logic [15:0] Sum,
  output logic        overflow
);

  logic [15:0] b_eff;

  // Subtraction as A + ~B + 1.
  assign b_eff = sub ? ~B : B;
  assign Sum   = A + b_eff + {15'd0, sub};

  // Overflow when both addends share a sign and the sum's sign differs.
  assign overflow = (A[15] == b_eff[15]) && (Sum[15] != A[15]);

endmodule

// File: rtl/rr_pick2.sv
// Two-way arbitration pick, purely combinational.
// Ports:
//   req0_i, req1_i  request lines
//   last_gnt_i      id of the most recent grant
//   rr_en_i         1 = round-robin on a tie, 0 = requester 0 always wins
//   winner_o        id of the selected requester (valid only with valid_o)
//   valid_o         at least one request is pending
module rr_pick2
  import addsub_arbiter_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_gnt_i,
  input  logic rr_en_i,
  output logic winner_o,
  output logic valid_o
);

  always_comb begin
    valid_o  = req0_i | req1_i;
    winner_o = REQ0;
    if (req0_i && req1_i) begin
      // Tie: round-robin hands it to whoever did not go last.
      winner_o = rr_en_i ? ~last_gnt_i : REQ0;
    end else if (req1_i) begin
      winner_o = REQ1;
    end
  end

endmodule

// File: rtl/addsub_arbiter.sv
// Shares one addsub_16bit between two requesters with a req/gnt/done
// handshake. IDLE arbitrates and latches the winner's operands; EXEC lets the
// adder evaluate them and registers result/ovfl, pulsing done for the winner.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   req0/a0/b0/sub0            requester 0 request and operands
//   req1/a1/b1/sub1            requester 1 request and operands
//   gnt0/gnt1                  one-cycle pulse: operands accepted
//   done0/done1                one-cycle pulse: result/ovfl valid
//   result/ovfl                last completed sum and signed overflow
//   busy                       operation in flight (EXEC)
module addsub_arbiter
  import addsub_arbiter_pkg::*;
#(
  parameter int WIDTH = ADDER_W,  // only 16 matches the shared adder
  parameter bit RR_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             sub0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic             sub1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] result,
  output logic             ovfl,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             sub_q, sub_d;
  // Doubles as the id of the in-flight operation while in EXEC.
  logic             last_gnt_q, last_gnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             ovfl_q, ovfl_d;
  logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic             done0_q, done0_d, done1_q, done1_d;

  logic             pick_id, pick_vld;
  logic [WIDTH-1:0] sum;
  logic             sum_ovf;

  rr_pick2 u_pick (
    .req0_i    (req0),
    .req1_i    (req1),
    .last_gnt_i(last_gnt_q),
    .rr_en_i   (RR_EN),
    .winner_o  (pick_id),
    .valid_o   (pick_vld)
  );

  addsub_16bit u_addsub (
    .A       (a_q),
    .B       (b_q),
    .sub     (sub_q),
    .Sum     (sum),
    .overflow(sum_ovf)
  );

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    sub_d      = sub_q;
    last_gnt_d = last_gnt_q;
    result_d   = result_q;
    ovfl_d     = ovfl_q;
    gnt0_d     = 1'b0;
    gnt1_d     = 1'b0;
    done0_d    = 1'b0;
    done1_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          last_gnt_d = pick_id;
          state_d    = EXEC;
          if (pick_id == REQ1) begin
            a_d    = a1;
            b_d    = b1;
            sub_d  = sub1;
            gnt1_d = 1'b1;
          end else begin
            a_d    = a0;
            b_d    = b0;
            sub_d  = sub0;
            gnt0_d = 1'b1;
          end
        end
      end
      EXEC: begin
        result_d = sum;
        ovfl_d   = sum_ovf;
        done0_d  = (last_gnt_q == REQ0);
        done1_d  = (last_gnt_q == REQ1);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      sub_q      <= 1'b0;
      last_gnt_q <= REQ1;  // requester 0 wins the first tie
      result_q   <= '0;
      ovfl_q     <= 1'b0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sub_q      <= sub_d;
      last_gnt_q <= last_gnt_d;
      result_q   <= result_d;
      ovfl_q     <= ovfl_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      done0_q    <= done0_d;
      done1_q    <= done1_d;
    end
  end

  assign gnt0   = gnt0_q;
  assign gnt1   = gnt1_q;
  assign done0  = done0_q;
  assign done1  = done1_q;
  assign result = result_q;
  assign ovfl   = ovfl_q;
  assign busy   = (state_q == EXEC);

endmodule

// File: tb/tb_addsub_arbiter.sv
module tb_addsub_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, sub0, req1, sub1;
  logic [15:0] a0, b0, a1, b1;

  logic        r_gnt0, r_gnt1, r_done0, r_done1, r_ovfl, r_busy;
  logic [15:0] r_result;
  logic        f_gnt0, f_gnt1, f_done0, f_done1, f_ovfl, f_busy;
  logic [15:0] f_result;

  always #5 clk = ~clk;

  addsub_arbiter #(.WIDTH(16), .RR_EN(1'b1)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .a0(a0), .b0(b0), .sub0(sub0),
    .req1(req1), .a1(a1), .b1(b1), .sub1(sub1),
    .gnt0(r_gnt0), .gnt1(r_gnt1), .done0(r_done0), .done1(r_done1),
    .result(r_result), .ovfl(r_ovfl), .busy(r_busy)
  );

  addsub_arbiter #(.WIDTH(16), .RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .a0(a0), .b0(b0), .sub0(sub0),
    .req1(req1), .a1(a1), .b1(b1), .sub1(sub1),
    .gnt0(f_gnt0), .gnt1(f_gnt1), .done0(f_done0), .done1(f_done1),
    .result(f_result), .ovfl(f_ovfl), .busy(f_busy)
  );

  typedef struct {
    logic        id;
    logic [15:0] res;
    logic        ov;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;

  // Reference arithmetic done in wide signed integers.
  function automatic exp_t model(input logic id, input logic [15:0] a, input logic [15:0] b,
                                 input logic sub);
    exp_t e;
    int   sa, sbv, r;
    sa   = $signed(a);
    sbv  = $signed(b);
    r    = sub ? (sa - sbv) : (sa + sbv);
    e.id  = id;
    e.res = r[15:0];
    e.ov  = (r > 32767) || (r < -32768);
    return e;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor on the round-robin instance, sampled mid-cycle.
  always @(negedge clk) begin
    n_vec++;
    if ((r_done0 && r_done1) || (r_gnt0 && r_gnt1) ||
        ((r_gnt0 || r_gnt1) && (r_done0 || r_done1))) begin
      n_err++;
      $display("FAIL exclusive: gnt=%b%b done=%b%b, at most one pulse required",
               r_gnt0, r_gnt1, r_done0, r_done1);
    end
    if (r_done0 || r_done1) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL sb_done: unexpected done=%b%b result=%h", r_done0, r_done1, r_result);
      end else begin
        mon_e = sb.pop_front();
        if (r_done1 !== mon_e.id || r_result !== mon_e.res || r_ovfl !== mon_e.ov) begin
          n_err++;
          $display("FAIL sb_result: got id=%b res=%h ov=%b, exp id=%b res=%h ov=%b",
                   r_done1, r_result, r_ovfl, mon_e.id, mon_e.res, mon_e.ov);
        end
      end
    end
  end

  task automatic test_reset;
    rst_n = 1'b0;
    req0 = 0; a0 = '0; b0 = '0; sub0 = 0;
    req1 = 0; a1 = '0; b1 = '0; sub1 = 0;
    tick(); tick();
    n_vec++;
    if ({r_gnt0, r_gnt1, r_done0, r_done1, r_busy, r_ovfl} !== 6'b0 || r_result !== 16'h0) begin
      n_err++;
      $display("FAIL reset_rr: flags=%b result=%h, exp all zero",
               {r_gnt0, r_gnt1, r_done0, r_done1, r_busy, r_ovfl}, r_result);
    end
    n_vec++;
    if ({f_gnt0, f_gnt1, f_done0, f_done1, f_busy, f_ovfl} !== 6'b0 || f_result !== 16'h0) begin
      n_err++;
      $display("FAIL reset_fp: flags=%b result=%h, exp all zero",
               {f_gnt0, f_gnt1, f_done0, f_done1, f_busy, f_ovfl}, f_result);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single(input string name, input logic id, input logic [15:0] a,
                             input logic [15:0] b, input logic sub,
                             input logic [15:0] exp_res, input logic exp_ov);
    if (id) begin req1 = 1; a1 = a; b1 = b; sub1 = sub; end
    else    begin req0 = 1; a0 = a; b0 = b; sub0 = sub; end
    tick();
    n_vec++;
    if ({r_gnt0, r_gnt1, r_busy, r_done0, r_done1} !== {~id, id, 1'b1, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL %s_gnt: gnt/busy/done=%b, exp %b", name,
               {r_gnt0, r_gnt1, r_busy, r_done0, r_done1}, {~id, id, 1'b1, 1'b0, 1'b0});
    end
    req0 = 0; req1 = 0;
    sb.push_back(model(id, a, b, sub));
    tick();
    n_vec++;
    if ({r_gnt0, r_gnt1, r_busy, r_done0, r_done1} !== {1'b0, 1'b0, 1'b0, ~id, id} ||
        r_result !== exp_res || r_ovfl !== exp_ov) begin
      n_err++;
      $display("FAIL %s_done: gnt/busy/done=%b res=%h ov=%b, exp %b res=%h ov=%b", name,
               {r_gnt0, r_gnt1, r_busy, r_done0, r_done1}, r_result, r_ovfl,
               {1'b0, 1'b0, 1'b0, ~id, id}, exp_res, exp_ov);
    end
  endtask

  task automatic test_tie;
    rst_n = 0; tick(); rst_n = 1;
    req0 = 1; a0 = 16'h0011; b0 = 16'h0022; sub0 = 0;
    req1 = 1; a1 = 16'h0100; b1 = 16'h0001; sub1 = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_vec++;
      if ({r_gnt0, r_gnt1} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
        n_err++;
        $display("FAIL tie_rr_%0d: gnt=%b%b, exp %b", k, r_gnt0, r_gnt1,
                 ((k % 2 == 0) ? 2'b10 : 2'b01));
      end
      n_vec++;
      if ({f_gnt0, f_gnt1} !== 2'b10) begin
        n_err++;
        $display("FAIL tie_fp_%0d: gnt=%b%b, exp 10", k, f_gnt0, f_gnt1);
      end
      if (k % 2 == 0) sb.push_back(model(1'b0, a0, b0, sub0));
      else            sb.push_back(model(1'b1, a1, b1, sub1));
      tick();
      if (k == 3) begin req0 = 0; req1 = 0; end
    end
    tick();
    n_vec++;
    if ({r_busy, r_gnt0, r_gnt1} !== 3'b000) begin
      n_err++;
      $display("FAIL tie_idle: busy/gnt=%b, exp 000", {r_busy, r_gnt0, r_gnt1});
    end
  endtask

  task automatic test_reset_mid;
    // Leave last_gnt = 0 so the pre-reset tie goes to requester 1.
    test_single("pre", 1'b0, 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0);
    req0 = 1; req1 = 1;
    tick();
    n_vec++;
    if ({r_gnt0, r_gnt1} !== 2'b01) begin
      n_err++;
      $display("FAIL mid_gnt: gnt=%b%b, exp 01", r_gnt0, r_gnt1);
    end
    rst_n = 0; req0 = 0; req1 = 0;
    tick();
    n_vec++;
    if ({r_busy, r_done0, r_done1, r_ovfl} !== 4'b0 || r_result !== 16'h0) begin
      n_err++;
      $display("FAIL mid_abort: busy/done/ovfl=%b result=%h, exp 0",
               {r_busy, r_done0, r_done1, r_ovfl}, r_result);
    end
    rst_n = 1;
    req0 = 1; req1 = 1;
    tick();
    n_vec++;
    if ({r_gnt0, r_gnt1} !== 2'b10) begin
      n_err++;
      $display("FAIL mid_retie: gnt=%b%b, exp 10", r_gnt0, r_gnt1);
    end
    req0 = 0; req1 = 0;
    sb.push_back(model(1'b0, a0, b0, sub0));
    tick();
  endtask

  task automatic test_back_to_back;
    req0 = 1; a0 = 16'h1000; b0 = 16'h0234; sub0 = 0;
    tick();
    n_vec++;
    if ({r_gnt0, r_busy} !== 2'b11) begin
      n_err++;
      $display("FAIL b2b_gnt1: gnt0/busy=%b, exp 11", {r_gnt0, r_busy});
    end
    sb.push_back(model(1'b0, 16'h1000, 16'h0234, 1'b0));
    a0 = 16'hFFFF;
    tick();
    n_vec++;
    if ({r_done0, r_gnt0} !== 2'b10 || r_result !== 16'h1234) begin
      n_err++;
      $display("FAIL b2b_done1: done0/gnt0=%b res=%h, exp 10 res=1234",
               {r_done0, r_gnt0}, r_result);
    end
    sb.push_back(model(1'b0, 16'hFFFF, 16'h0234, 1'b0));
    tick();
    n_vec++;
    if ({r_gnt0, r_busy} !== 2'b11) begin
      n_err++;
      $display("FAIL b2b_gnt2: gnt0/busy=%b, exp 11", {r_gnt0, r_busy});
    end
    req0 = 0;
    tick();
    n_vec++;
    if (r_done0 !== 1'b1 || r_result !== 16'h0233 || r_ovfl !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_done2: done0=%b res=%h ov=%b, exp 1 res=0233 ov=0",
               r_done0, r_result, r_ovfl);
    end
  endtask

  initial begin
    test_reset();
    test_single("add",    1'b0, 16'h1234, 16'h0101, 1'b0, 16'h1335, 1'b0);
    test_single("sub",    1'b1, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0);
    test_single("ovf",    1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b1);
    test_single("ovfsub", 1'b1, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1);
    test_tie();
    test_reset_mid();
    test_back_to_back();
    tick(); tick();
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: %0d results outstanding, exp 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/addsub_arbiter.md
Name: addsub_arbiter

Overview:
- Shares one addsub_16bit instance between two requesters, e.g. the ALU path (requester 0) and the branch/PC-offset path (requester 1).
- Each requester uses a req/gnt/done handshake.
- The block latches the winning operands, drives the shared adder from registers, and returns a registered result and overflow flag.
- It is a two-state sequencer with a round-robin or fixed-priority pointer.

Parameters:
- WIDTH, 16, operand/result width; only 16 is supported (must match addsub_16bit).
- RR_EN, 1, 1 = round-robin between requesters; 0 = fixed priority, requester 0 wins.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  synchronous active-low reset
- req0  input  1  requester 0 request; hold high with operands stable until gnt0
- a0  input  WIDTH  requester 0 operand A
- b0  input  WIDTH  requester 0 operand B
- sub0  input  1  requester 0 op: 0 = A+B, 1 = A-B
- req1, a1, b1, sub1  input  1/WIDTH/WIDTH/1  requester 1, same meaning
- gnt0, gnt1  output  1 each  one-cycle pulse: operands accepted
- done0, done1  output  1 each  one-cycle pulse: result/ovfl valid for that requester
- result  output  WIDTH  last completed Sum from addsub_16bit
- ovfl  output  1  last completed overflow from addsub_16bit
- busy  output  1  high while an operation is in flight (state EXEC)

Behaviour:
- Reset (rst_n = 0 at a rising edge) sets: state = IDLE; gnt0/gnt1/done0/done1/busy/ovfl = 0; result = 0; operand registers = 0; last_gnt = 1 (so requester 0 wins the first tie).
- All outputs are registered. No combinational path from inputs to outputs.
- States:
  - IDLE: arbitration happens here.
  - EXEC: the adder evaluates the latched operands.
- IDLE, edge ending cycle T, any req high:
  - Pick the winner.
  - Latch its a/b/sub into the operand registers.
  - Record the winner id and set last_gnt = winner.
  - Go to EXEC.
  - gnt_winner = 1 and busy = 1 during cycle T+1.
- IDLE, no req: stay in IDLE; all pulses 0.
- EXEC, edge ending T+1:
  - Register result <= Sum and ovfl <= overflow from the shared adder.
  - done_winner = 1 during T+2; return to IDLE; busy = 0.
- Latency: gnt is 1 cycle after the request is sampled; done is 2 cycles after.
- Throughput: one operation per 2 cycles. A new request can be sampled at the end of the cycle in which done pulses.
- Arbitration when both req high:
  - RR_EN = 1: grant the requester not equal to last_gnt.
  - RR_EN = 0: always grant requester 0.
  - Only one req high: grant it regardless of last_gnt.
- Request rules:
  - Requests are not sampled in EXEC. A req held through EXEC is re-arbitrated in the next IDLE cycle.
  - A requester that sees gnt must drop req by the next cycle unless it is issuing a new operation.
- The loser of a tie keeps req high and is granted in the next IDLE sample. With RR_EN = 1 this guarantees no starvation.
- Operand changes after gnt have no effect on the in-flight operation.
- result/ovfl hold their value until the next done; they are not cleared by IDLE.
- At most one gnt and at most one done are high in any cycle. gnt and done never coincide.
- Reset mid-operation (EXEC): the operation is aborted, no done is issued, and result returns to 0.
- Arithmetic: result and ovfl are exactly addsub_16bit's Sum and overflow for the latched A, B, sub. There is no extra saturation or extension.

Decomposition:
- Shared package:
  - state encoding constants: IDLE = 1'b0, EXEC = 1'b1
  - requester id constants: REQ0 = 1'b0, REQ1 = 1'b1
- Sub-modules:
  - Instantiate the existing addsub_16bit once (inputs from the operand registers).
  - The arbitration pick is a natural small combinational sub-module, rr_pick2 (inputs req0, req1, last_gnt, RR_EN; output winner id and valid).

Test Plan:
- Single add: req0, a0 = 16'h1234, b0 = 16'h0101, sub0 = 0 at cycle T -> gnt0 in T+1, done0 in T+2, result = 16'h1335, ovfl = 0.
- Single subtract: req1, a1 = 16'h0005, b1 = 16'h0007, sub1 = 1 -> gnt1 then done1, result = 16'hFFFE, ovfl = 0; gnt0/done0 stay 0.
- Signed overflow: req0, a0 = 16'h7FFF, b0 = 16'h0001, sub0 = 0 -> done0 with ovfl = 1 and result equal to addsub_16bit's Sum for those operands.
- Tie after reset: req0 and req1 both high and held -> RR_EN = 1: grant order 0,1,0,1 with gnt pulses 2 cycles apart; RR_EN = 0: gnt0 every time.
- Reset mid-operation: rst_n = 0 in the gnt cycle (EXEC) -> no done pulse; next cycle busy = 0, result = 0, ovfl = 0, and the next tie goes to requester 0.
- Held req and stale operands: req0 kept high across EXEC and a0 changed to 16'hFFFF in the gnt cycle -> the first result uses the latched a0; a second gnt0 pulses exactly at the done0 cycle + 1.
